fb_write_arbiter: RTL

Shares the single write port of the VGA framebuffer among three sources: processor pixel stores, the turtle line-draw engine, and a built-in clear-screen sequencer. The block sits between those sources and the framebuffer RAM write side, all in the system clock domain. It issues at most one framebuffer write per cycle, with registered outputs. Requesters are served round-robin, and a clear command has priority over both.

---
 rtl/fb_write_arbiter_if.sv | 43 ++++
 rtl/fb_write_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - request, clear and framebuffer write-side signals of the write arbiter
interface fb_write_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic              p_ready;

  logic              l_valid;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_data;
  logic              l_ready;

  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;

  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              oob_drop;

  // Side that drives requests and observes the framebuffer write port.
  modport master (
    output p_valid, p_addr, p_data,
    output l_valid, l_addr, l_data,
    output clr_start, clr_color,
    input  p_ready, l_ready, clr_busy, clr_done,
    input  fb_we, fb_addr, fb_data, oob_drop
  );

  // The arbiter itself.
  modport slave (
    input  p_valid, p_addr, p_data,
    input  l_valid, l_addr, l_data,
    input  clr_start, clr_color,
    output p_ready, l_ready, clr_busy, clr_done,
    output fb_we, fb_addr, fb_data, oob_drop
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin framebuffer write arbiter with priority clear-screen sweep
module fb_write_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int FB_DEPTH = 307200
) (
  input  logic               clock,
  input  logic               reset,
  fb_write_arbiter_if.slave  bus
);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic GRANT_P = 1'b0;
  localparam logic GRANT_L = 1'b1;

  // One extra bit so FB_DEPTH is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  state_t            state_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] clr_color_q;
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [DATA_W-1:0] fb_data_q;
  logic              clr_busy_q;
  logic              clr_done_q;
  logic              oob_drop_q;

  logic              arb_open;
  logic              grant_p;
  logic              grant_l;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_in_range;

  // Grant decision: a clear request blocks both sources; under contention the
  // source that did not win last time is served.
  always_comb begin
    arb_open     = (state_q == ARB) && !bus.clr_start;
    grant_p      = arb_open && bus.p_valid &&
                   (!bus.l_valid || (last_grant_q == GRANT_L));
    grant_l      = arb_open && bus.l_valid &&
                   (!bus.p_valid || (last_grant_q == GRANT_P));
    win_addr     = grant_l ? bus.l_addr : bus.p_addr;
    win_data     = grant_l ? bus.l_data : bus.p_data;
    win_in_range = ({1'b0, win_addr} < DEPTH_X);
  end

  assign bus.p_ready  = grant_p;
  assign bus.l_ready  = grant_l;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;
  assign bus.oob_drop = oob_drop_q;

  // Arbitration/clear FSM with all write-port outputs registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB;
      last_grant_q <= GRANT_L;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      oob_drop_q   <= 1'b0;
    end else begin
      fb_we_q    <= 1'b0;
      oob_drop_q <= 1'b0;
      clr_done_q <= 1'b0;
      case (state_q)
        ARB: begin
          clr_busy_q <= 1'b0;
          if (bus.clr_start) begin
            clr_color_q <= bus.clr_color;
            clr_cnt_q   <= '0;
            state_q     <= CLEAR;
          end else if (grant_p || grant_l) begin
            last_grant_q <= grant_l ? GRANT_L : GRANT_P;
            if (win_in_range) begin
              fb_we_q   <= 1'b1;
              fb_addr_q <= win_addr;
              fb_data_q <= win_data;
            end else begin
              // Accepted but discarded; address/data keep their last value.
              oob_drop_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          fb_we_q     <= 1'b1;
          fb_addr_q   <= clr_cnt_q;
          fb_data_q   <= clr_color_q;
          clr_busy_q  <= 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            clr_done_q <= 1'b1;
            state_q    <= ARB;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

endmodule
